// File: rtl/alu_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_wb_stage
//  Purpose  : 2-entry writeback FIFO behind the ALU plus Z/N/C/V flag state.
//             Optional macro ALU_WB_OFL_TRAP_EN drops signed-overflow results
//             and pulses ofl_trap instead.
//  Revision : 1.0  initial release
// ============================================================================
module alu_wb_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_ofl,
    input  logic                  in_cout,
    input  logic                  in_z,
    input  logic                  in_sign,
    input  logic                  in_setflags,
    input  logic [REG_ADDR_W-1:0] in_dest,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [REG_ADDR_W-1:0] out_dest,
`ifdef ALU_WB_OFL_TRAP_EN
    output logic                  ofl_trap,
`endif
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  flag_c,
    output logic                  flag_v
);

    localparam logic [1:0] c_FULL = 2'd2;

    logic [DATA_W-1:0]     r_data [2];
    logic [REG_ADDR_W-1:0] r_dest [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_wr;

    assign in_ready  = (r_count != c_FULL) && rst;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_data[r_rptr];
    assign out_dest  = r_dest[r_rptr];

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

`ifdef ALU_WB_OFL_TRAP_EN
    // Signed overflow is accepted on the handshake but never stored.
    logic r_ofl_trap;
    assign w_wr     = w_push && !(in_sign && in_ofl);
    assign ofl_trap = r_ofl_trap;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ofl_trap <= 1'b0;
        end else begin
            r_ofl_trap <= w_push && in_sign && in_ofl;
        end
    end
`else
    assign w_wr = w_push;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_dest[i] <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_data[r_wptr] <= in_data;
                r_dest[r_wptr] <= in_dest;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            // Flags follow issue order, so they update on the push edge.
            if (w_push && in_setflags) begin
                flag_z <= in_z;
                flag_n <= in_data[DATA_W-1];
                flag_c <= in_cout;
                flag_v <= in_sign ? in_ofl : 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_wb_stage
//  Purpose  : Self-checking bench for alu_wb_stage (queue-based reference).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        in_ofl, in_cout, in_z, in_sign, in_setflags;
    logic [2:0]  in_dest;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_dest;
    logic        flag_z, flag_n, flag_c, flag_v;
`ifdef ALU_WB_OFL_TRAP_EN
    logic        ofl_trap;
`endif

    alu_wb_stage #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ofl(in_ofl), .in_cout(in_cout), .in_z(in_z), .in_sign(in_sign),
        .in_setflags(in_setflags), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dest(out_dest),
`ifdef ALU_WB_OFL_TRAP_EN
        .ofl_trap(ofl_trap),
`endif
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of pending results plus four flag bits.
    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  r;
    } ent_t;
    ent_t q[$];
    logic m_z = 1'b0, m_n = 1'b0, m_c = 1'b0, m_v = 1'b0;
    logic m_trap = 1'b0;
    logic m_acc = 1'b0;
    logic chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_trap = 0; m_acc = 0;
        end else begin
            m_acc  = in_valid && (q.size() < 2);
            m_trap = 1'b0;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (m_acc) begin
`ifdef ALU_WB_OFL_TRAP_EN
                if (in_sign && in_ofl) m_trap = 1'b1;
                else q.push_back('{d: in_data, r: in_dest});
`else
                q.push_back('{d: in_data, r: in_dest});
`endif
                if (in_setflags) begin
                    m_z = in_z;
                    m_n = in_data[15];
                    m_c = in_cout;
                    m_v = in_sign && in_ofl;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("in_ready", in_ready, (q.size() < 2) && rst);
            chk1("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk16("out_data", out_data, q[0].d);
                chk16("out_dest", 16'(out_dest), 16'(q[0].r));
            end
            chk1("flag_z", flag_z, m_z);
            chk1("flag_n", flag_n, m_n);
            chk1("flag_c", flag_c, m_c);
            chk1("flag_v", flag_v, m_v);
`ifdef ALU_WB_OFL_TRAP_EN
            chk1("ofl_trap", ofl_trap, m_trap);
`endif
        end
    end

    // Applies inputs (caller sits at negedge+2) and advances one cycle.
    task automatic step(input logic v, input logic [15:0] d, input logic [2:0] r,
                        input logic z, input logic c, input logic o, input logic s,
                        input logic sf, input logic ordy, input logic rs);
        in_valid = v; in_data = d; in_dest = r; in_z = z; in_cout = c;
        in_ofl = o; in_sign = s; in_setflags = sf; out_ready = ordy; rst = rs;
        @(negedge clk);
        #2;
    endtask

    initial begin
        in_valid = 0; in_data = 0; in_dest = 0; in_z = 0; in_cout = 0;
        in_ofl = 0; in_sign = 0; in_setflags = 0; out_ready = 0; rst = 0;
        @(negedge clk);
        #2;
        step(0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk16("rst_out_data", out_data, 16'h0);

        // Single result after reset release
        step(1, 16'h1234, 3, 0, 1, 0, 0, 1, 0, 1);
        chk1("single_valid", out_valid, 1'b1);
        chk16("single_data", out_data, 16'h1234);
        chk16("single_dest", 16'(out_dest), 16'd3);
        chk1("single_fz", flag_z, 1'b0);
        chk1("single_fn", flag_n, 1'b0);
        chk1("single_fc", flag_c, 1'b1);
        chk1("single_fv", flag_v, 1'b0);
        step(0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Back-pressure fill
        step(1, 16'hAAAA, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 16'h5555, 2, 0, 0, 0, 0, 0, 0, 1);
        chk1("full_in_ready", in_ready, 1'b0);
        step(1, 16'h1111, 4, 0, 0, 0, 0, 0, 0, 1);
        chk16("full_head", out_data, 16'hAAAA);
        step(0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk16("bp_second", out_data, 16'h5555);
        chk1("bp_ready_back", in_ready, 1'b1);
        step(0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk1("bp_empty", out_valid, 1'b0);

        // Flag semantics
        step(1, 16'h8000, 5, 0, 0, 1, 1, 1, 1, 1);
        chk1("fl_n1", flag_n, 1'b1);
        chk1("fl_v1", flag_v, 1'b1);
        step(1, 16'h0000, 5, 1, 1, 0, 0, 0, 1, 1);
        chk1("fl_hold_z", flag_z, 1'b0);
        chk1("fl_hold_n", flag_n, 1'b1);
        step(1, 16'h0001, 6, 0, 0, 1, 0, 1, 1, 1);
        chk1("fl_unsigned_v", flag_v, 1'b0);
        chk1("fl_unsigned_n", flag_n, 1'b0);
        step(0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Reset mid-operation with two entries buffered
        step(1, 16'hBEEF, 1, 1, 1, 0, 0, 1, 0, 1);
        step(1, 16'hCAFE, 2, 0, 1, 0, 0, 1, 0, 1);
        step(0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk1("mid_rst_valid", out_valid, 1'b0);
        chk1("mid_rst_ready", in_ready, 1'b0);
        chk1("mid_rst_fc", flag_c, 1'b0);
        chk16("mid_rst_data", out_data, 16'h0);
        step(1, 16'h4242, 7, 0, 0, 0, 0, 0, 0, 1);
        chk16("post_rst_data", out_data, 16'h4242);
        step(0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Signed overflow result
        step(1, 16'h7FFF, 2, 0, 0, 1, 1, 1, 0, 1);
        chk1("trap_fv", flag_v, 1'b1);
`ifdef ALU_WB_OFL_TRAP_EN
        chk1("trap_pulse", ofl_trap, 1'b1);
        chk1("trap_not_queued", out_valid, 1'b0);
        step(0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk1("trap_pulse_end", ofl_trap, 1'b0);
`else
        chk1("ofl_queued", out_valid, 1'b1);
        chk16("ofl_data", out_data, 16'h7FFF);
        step(0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 1);
`endif
        step(0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Streaming: the newest push is always the head when draining each cycle
        for (int k = 0; k < 8; k++) begin
            step(1, 16'(16'h1000 + k * 16'h0101), 3'(k), 0, 0, 0, 0, 0, 1, 1);
            chk1("stream_valid", out_valid, 1'b1);
            chk16("stream_data", out_data, 16'(16'h1000 + k * 16'h0101));
        end
        step(0, 16'h0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Randomized traffic; an unaccepted request is held stable
        for (int i = 0; i < 2000; i++) begin
            if (in_valid && !m_acc && rst) begin
                step(1, in_data, in_dest, in_z, in_cout, in_ofl, in_sign, in_setflags,
                     ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) != 0));
            end else begin
                step(($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom),
                     1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                     1'($urandom), 1'($urandom),
                     ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) != 0));
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_wb_stage.md
# alu_wb_stage

Writeback-side buffer that sits directly downstream of the ALU. It captures each ALU result (`Out`, `Ofl`, `Cout`, `Z`) together with its destination register, and holds it in a 2-entry FIFO with valid/ready handshakes on both sides. It also maintains the architectural Z/N/C/V condition flags for later branch evaluation. This decouples ALU issue from register-file writeback stalls.

## Interface
- `DATA_W`, 16, result width (matches ALU `Out`).
- `REG_ADDR_W`, 3, destination register index width.
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low: sampled on rising `clk`, state cleared when `rst`==0.
- `in_valid`  in  1  ALU result valid this cycle.
- `in_ready`  out  1  stage can accept a result.
- `in_data`  in  DATA_W  ALU `Out`.
- `in_ofl`  in  1  ALU `Ofl`.
- `in_cout`  in  1  ALU `Cout`.
- `in_z`  in  1  ALU `Z`.
- `in_sign`  in  1  operation was signed (same value driven to ALU `sign`).
- `in_setflags`  in  1  this result updates the flags.
- `in_dest`  in  REG_ADDR_W  destination register.
- `out_valid`  out  1  head entry valid for writeback.
- `out_ready`  in  1  register file consumes head this cycle.
- `out_data`  out  DATA_W  head entry data.
- `out_dest`  out  REG_ADDR_W  head entry destination.
- `flag_z`, `flag_n`, `flag_c`, `flag_v`  out  1 each  architectural flags.
- `ofl_trap`  out  1  overflow trap pulse (only with `ALU_WB_OFL_TRAP_EN`).

## Operation
- **Storage.** 2-entry circular FIFO of {data, dest}, with 1-bit write pointer, 1-bit read pointer, and 2-bit count (0..2).
- **Push.** Occurs when `in_valid && in_ready`.
- **Pop.** Occurs when `out_valid && out_ready`.
- **Ready/valid.** `in_ready` = (count < 2) && `rst`==1. `out_valid` = (count != 0).
- **Count update:**
  - push only: +1.
  - pop only: −1.
  - push and pop: unchanged.
  - At count==2 no push can occur.
  - At count==0 no pop can occur.
  - Push and pop at count==0 cannot coincide.
- **Pointer wrap.** Pointers wrap 1→0.
- **Head outputs.** `out_data`/`out_dest` always reflect the entry at the read pointer. When empty, they show the last-popped or reset contents.
- **Flags.** Updated on push, not on pop, and only if `in_setflags`=1:
  - `flag_z` <= `in_z`.
  - `flag_n` <= `in_data[DATA_W-1]`.
  - `flag_c` <= `in_cout`.
  - `flag_v` <= `in_sign ? in_ofl : 0`.
- **Flag hold.** Flags hold when `in_setflags`=0 or when no push occurs.
- **In-order guarantee.** Flags reflect ALU issue order, and entries retire in push order.
- **Reset** (`rst`==0 at rising edge):
  - count, pointers, flags, and all storage are cleared to 0.
  - `out_valid`=0, `out_data`=0, `out_dest`=0, `in_ready`=0, `ofl_trap`=0.
  - Reset mid-operation discards all buffered entries. No pop is reported for them.

## Timing
- **Push to output.** Push at edge N makes the entry visible on `out_valid`/`out_data` after edge N. Latency is 1 cycle when empty.
- **No bypass.** There is no combinational path from `in_*` to `out_*`.
- **Flag timing.** Flags change at the edge where the push is accepted.
- **Ready path.** `in_ready` depends only on registered count and `rst`. There is no combinational path from `out_ready` to `in_ready`. A pop in cycle N frees a slot visible in cycle N+1.
- **Throughput.** Sustained 1 result/cycle when `out_ready` is held at 1 (count oscillates 0↔1 or holds at 1).
- **Handshake rules.**
  - Upstream must hold `in_*` stable while `in_valid`=1 and `in_ready`=0.
  - This stage holds `out_*` stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- **Macro:** `ALU_WB_OFL_TRAP_EN`.
- **Defined:**
  - A push with `in_sign`=1 and `in_ofl`=1 is not written into the FIFO; count and pointers are unchanged.
  - Flags still update per the `in_setflags` rule.
  - `ofl_trap` pulses 1 for exactly the cycle after that push edge.
  - Unsigned operations are never trapped.
- **Undefined:**
  - The `ofl_trap` port is absent.
  - Overflowed results are enqueued normally.

## Test plan
- **Reset then single result.** Release `rst`, push data=0x1234, dest=3, setflags=1, z=0, cout=1.
  - Next cycle: `out_valid`=1, `out_data`=0x1234, `out_dest`=3.
  - Flags: z=0, n=0, c=1, v=0.
- **Back-pressure fill.** Hold `out_ready`=0 and push 0xAAAA then 0x5555.
  - `in_ready`=0 after the second push, and a third `in_valid` is not accepted.
  - Raise `out_ready`: pops are 0xAAAA then 0x5555 in order, and `in_ready` returns to 1 one cycle after the first pop.
- **Streaming.** Push 8 results on consecutive cycles with `out_ready`=1.
  - All 8 pop in order, with no bubbles after the first.
  - Exercises pointer wrap and simultaneous push/pop at count=1.
- **Flag semantics.**
  - Push data=0x8000, setflags=1, sign=1, ofl=1, z=0 → n=1, v=1.
  - Then push with setflags=0 and z=1 → flags unchanged.
  - Then push sign=0, ofl=1, setflags=1 → v=0.
- **Reset mid-operation.** With 2 entries buffered, drive `rst`=0 for one edge.
  - Then: `out_valid`=0, `in_ready`=0 during reset, all flags 0, `out_data`=0.
  - Next push after release appears normally.
- **Trap (macro defined).** Push sign=1, ofl=1, data=0x7FFF.
  - `ofl_trap`=1 for one cycle, `out_valid` stays 0, `flag_v`=1 if setflags.
  - Same stimulus with the macro undefined: entry is enqueued.
